// File: rtl/sme_match_serializer_pkg.sv
// Shared types and helpers for the match-output serializer.
// Optional build macro SME_DEDUP_EN masks repeated IDs within a packet.
package sme_match_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TERM  = 2'd2
   } state_t;

   localparam int unsigned ID_NONE = 0;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/sme_match_serializer_if.sv
// Match serializer bus: packed-ID input stream and rule-ID output stream.
// The DUT side uses the slave modport, the driver side uses master.
interface sme_match_serializer_if #(
   parameter int SLOTS     = 4,
   parameter int ID_WIDTH  = 16,
   parameter int CNT_WIDTH = 8
);
   logic [SLOTS*ID_WIDTH-1:0] s_data;
   logic                      s_eop;
   logic                      s_valid;
   logic                      s_ready;
   logic [ID_WIDTH-1:0]       m_rule_id;
   logic                      m_last;
   logic [CNT_WIDTH-1:0]      m_count;
   logic                      m_trunc;
   logic                      m_valid;
   logic                      m_ready;

   modport master (
      output s_data, s_eop, s_valid, m_ready,
      input  s_ready, m_rule_id, m_last, m_count, m_trunc, m_valid
   );

   modport slave (
      input  s_data, s_eop, s_valid, m_ready,
      output s_ready, m_rule_id, m_last, m_count, m_trunc, m_valid
   );
endinterface

// File: rtl/sme_match_serializer_slot_select.sv
// Priority picker over the pending-slot mask, lowest index wins.
// Produces a one-hot grant and the matching encoded index.
module sme_slot_select
   import sme_match_serializer_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int IW    = idx_w(SLOTS)
) (
   input  logic [SLOTS-1:0] i_pend,
   output logic [SLOTS-1:0] o_grant,
   output logic [IW-1:0]    o_idx
);

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      for (int k = SLOTS - 1; k >= 0; k--) begin
         if (i_pend[k]) begin
            o_grant    = '0;
            o_grant[k] = 1'b1;
            o_idx      = IW'(k);
         end
      end
   end

endmodule

// File: rtl/sme_match_serializer.sv
// Serializes packed match words into one rule ID per beat plus a terminator.
// Build macro SME_DEDUP_EN enables per-packet duplicate-ID masking.
module sme_match_serializer
   import sme_match_serializer_pkg::*;
#(
   parameter int SLOTS           = 4,
   parameter int ID_WIDTH        = 16,
   parameter int FIFO_ADDR_WIDTH = 2,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CNT_WIDTH-1:0] cfg_max_matches,
   output logic [31:0]          stat_dropped,
   sme_match_serializer_if.slave bus
);

   localparam int AW    = FIFO_ADDR_WIDTH;
   localparam int DEPTH = 1 << AW;
   localparam int IW    = idx_w(SLOTS);
   localparam int DW    = SLOTS * ID_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [ID_WIDTH-1:0]  ID_Z    = ID_WIDTH'(ID_NONE);

   // FIFO entry is {eop, packed IDs}
   logic [DW:0]          r_mem [DEPTH];
   logic [AW:0]          r_wptr;
   logic [AW:0]          r_rptr;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_load;
   logic [DW:0]          w_head;

   state_t               r_state;
   state_t               w_next;
   state_t               w_load_st;
   logic [ID_WIDTH-1:0]  r_ids [SLOTS];
   logic [SLOTS-1:0]     r_pend;
   logic                 r_eop;
   logic                 r_first;
   logic                 r_trunc;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_cap;
   logic [31:0]          r_dropped;

   logic [ID_WIDTH-1:0]  w_slot [SLOTS];
   logic [SLOTS-1:0]     w_new_pend;
   logic [SLOTS-1:0]     w_grant;
   logic [SLOTS-1:0]     w_pend_left;
   logic [IW-1:0]        w_idx;
   logic [ID_WIDTH-1:0]  w_cur_id;
   logic                 w_capped;
   logic                 w_drain_acc;
   logic                 w_drop;
   logic                 w_term_acc;
   logic                 w_word_done;
   logic                 w_load_ok;
   logic                 w_first;

   assign w_empty     = (r_wptr == r_rptr);
   assign w_full      = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push      = bus.s_valid & ~w_full;
   assign w_head      = r_mem[r_rptr[AW-1:0]];
   assign bus.s_ready = ~w_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {bus.s_eop, bus.s_data};
            r_wptr                <= r_wptr + 1'b1;
         end
         if (w_load) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   sme_slot_select #(
      .SLOTS (SLOTS),
      .IW    (IW)
   ) u_sel (
      .i_pend  (r_pend),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      assign w_slot[k] = w_head[k*ID_WIDTH +: ID_WIDTH];
   end

   assign w_cur_id    = r_ids[w_idx];
   assign w_capped    = (r_cap != '0) && (r_cnt == r_cap);
   assign w_drain_acc = (r_state == ST_DRAIN) & ~w_capped & bus.m_ready;
   assign w_drop      = (r_state == ST_DRAIN) & w_capped;
   assign w_term_acc  = (r_state == ST_TERM) & bus.m_ready;
   assign w_pend_left = r_pend & ~w_grant;
   assign w_word_done = w_drain_acc & (w_pend_left == '0);
   // terminator accept and last-slot accept both reload without a bubble
   assign w_load_ok   = (r_state == ST_IDLE) | (w_word_done & ~r_eop) | w_term_acc;
   assign w_load      = w_load_ok & ~w_empty;
   assign w_first     = r_first | w_term_acc;

`ifdef SME_DEDUP_EN
   logic [ID_WIDTH-1:0] r_last_id;
   logic                r_last_vld;
   logic [ID_WIDTH-1:0] w_prev_id;
   logic                w_prev_vld;

   assign w_prev_vld = ~w_first & (w_drain_acc | r_last_vld);
   assign w_prev_id  = w_drain_acc ? w_cur_id : r_last_id;
`endif

   always_comb begin
      w_new_pend = '0;
      for (int k = 0; k < SLOTS; k++) begin
         w_new_pend[k] = (w_slot[k] != ID_Z);
`ifdef SME_DEDUP_EN
         for (int j = 0; j < k; j++) begin
            if (w_slot[j] == w_slot[k]) w_new_pend[k] = 1'b0;
         end
         if (w_prev_vld && (w_prev_id == w_slot[k])) w_new_pend[k] = 1'b0;
`endif
      end
   end

   always_comb begin
      w_load_st = ST_IDLE;
      if (|w_new_pend) w_load_st = ST_DRAIN;
      else if (w_head[DW]) w_load_st = ST_TERM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_load) w_next = w_load_st;
         end
         ST_DRAIN: begin
            if (w_drop) begin
               w_next = r_eop ? ST_TERM : ST_IDLE;
            end else if (w_word_done) begin
               if (r_eop)       w_next = ST_TERM;
               else if (w_load) w_next = w_load_st;
               else             w_next = ST_IDLE;
            end
         end
         ST_TERM: begin
            if (w_term_acc) w_next = w_load ? w_load_st : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.m_valid   = 1'b0;
      bus.m_last    = 1'b0;
      bus.m_rule_id = ID_Z;
      bus.m_count   = '0;
      bus.m_trunc   = 1'b0;
      unique case (r_state)
         ST_DRAIN: begin
            bus.m_valid   = ~w_capped;
            bus.m_rule_id = w_capped ? ID_Z : w_cur_id;
         end
         ST_TERM: begin
            bus.m_valid = 1'b1;
            bus.m_last  = 1'b1;
            bus.m_count = r_cnt;
            bus.m_trunc = r_trunc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SLOTS; k++) begin
            r_ids[k] <= '0;
         end
         r_pend    <= '0;
         r_eop     <= 1'b0;
         r_first   <= 1'b1;
         r_trunc   <= 1'b0;
         r_cnt     <= '0;
         r_cap     <= '0;
         r_dropped <= '0;
`ifdef SME_DEDUP_EN
         r_last_id  <= '0;
         r_last_vld <= 1'b0;
`endif
      end else begin
         if (w_drain_acc) begin
            r_pend <= w_pend_left;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
`ifdef SME_DEDUP_EN
            r_last_id  <= w_cur_id;
            r_last_vld <= 1'b1;
`endif
         end
         if (w_drop) begin
            r_pend    <= '0;
            r_trunc   <= 1'b1;
            r_dropped <= r_dropped + 32'(popcount(8'(r_pend)));
         end
         if (w_term_acc) begin
            r_cnt   <= '0;
            r_trunc <= 1'b0;
            r_first <= 1'b1;
`ifdef SME_DEDUP_EN
            r_last_vld <= 1'b0;
`endif
         end
         // new packet's cap comes from this cycle's cfg even on terminator accept
         if (w_load) begin
            for (int k = 0; k < SLOTS; k++) begin
               r_ids[k] <= w_slot[k];
            end
            r_pend  <= w_new_pend;
            r_eop   <= w_head[DW];
            r_first <= 1'b0;
            if (w_first) r_cap <= cfg_max_matches;
         end
      end
   end

   assign stat_dropped = r_dropped;

endmodule
